// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM byte-serial RAM arbiter.
// FSM states, owner codes, request-length codes and reset polarity.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic RST_ACTIVE = 1'b0;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    // Any length other than 1 or 2 is serviced as a full word.
    function automatic logic [2:0] len_decode(input logic [2:0] len);
        case (len)
            LEN_1:   return LEN_1;
            LEN_2:   return LEN_2;
            default: return LEN_4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_pack.sv
// Byte-lane helper: selects the outgoing store byte and merges an incoming
// read byte into the partially assembled little-endian word.
module mem_byte_pack #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        wr_idx,
    output logic [7:0]        wr_byte,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [7:0]        rd_byte,
    input  logic [1:0]        rd_idx,
    output logic [DATA_W-1:0] rd_next
);

    always_comb begin
        wr_byte = '0;
        rd_next = rd_word;
        for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            if (wr_idx == i[1:0]) begin
                wr_byte = wdata[8*i +: 8];
            end
            if (rd_idx == i[1:0]) begin
                rd_next[8*i +: 8] = rd_byte;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single 8-bit RAM port between instruction fetch and MEM,
// serialising 1/2/4-byte requests into byte beats (MEM has priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              prediction_res,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall_req,
    output logic              mem_stall_req
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic [ADDR_W-1:0] beat_addr;
    logic [1:0]        wr_idx;
    logic [1:0]        rd_idx;
    logic [7:0]        wr_byte;
    logic [DATA_W-1:0] rd_next;

    assign beat_addr = base_q + {{(ADDR_W-3){1'b0}}, cnt_q};
    assign wr_idx    = cnt_q[1:0];
    // Read data trails its address by two edges, so byte k lands when cnt = k+2.
    assign rd_idx    = cnt_q[1:0] - 2'd2;

    mem_byte_pack #(
        .DATA_W (DATA_W)
    ) u_pack (
        .wdata   (wdata_q),
        .wr_idx  (wr_idx),
        .wr_byte (wr_byte),
        .rd_word (rd_buf_q),
        .rd_byte (ram_din),
        .rd_idx  (rd_idx),
        .rd_next (rd_next)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rd_buf_d    = rd_buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A requester is masked during its own done cycle so it is not re-granted.
                if (mem_req && !mem_done_q) begin
                    owner_d  = OWNER_MEM;
                    base_d   = mem_addr;
                    len_d    = len_decode(mem_len);
                    wdata_d  = mem_wdata;
                    rd_buf_d = '0;
                    ram_a_d  = mem_addr;
                    cnt_d    = 3'd1;
                    if (mem_we) begin
                        state_d    = ST_WR;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d  = ST_RD;
                        ram_wr_d = 1'b0;
                    end
                end else if (if_req && !if_done_q && prediction_res) begin
                    owner_d  = OWNER_IF;
                    base_d   = if_addr;
                    len_d    = LEN_4;
                    rd_buf_d = '0;
                    ram_a_d  = if_addr;
                    ram_wr_d = 1'b0;
                    cnt_d    = 3'd1;
                    state_d  = ST_RD;
                end
            end

            ST_RD: begin
                if (owner_q == OWNER_IF && !prediction_res) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q >= 3'd2) begin
                        rd_buf_d = rd_next;
                    end
                    if (cnt_q < len_q) begin
                        ram_a_d = beat_addr;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (owner_q == OWNER_IF) begin
                            if_done_d = 1'b1;
                            if_inst_d = rd_next;
                        end else begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = rd_next;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_WR: begin
                if (cnt_q == len_q) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    ram_a_d    = beat_addr;
                    ram_dout_d = wr_byte;
                    cnt_d      = cnt_q + 3'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_IF;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rd_buf_q    <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rd_buf_q    <= rd_buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a         = ram_a_q;
    assign ram_dout      = ram_dout_q;
    assign ram_wr        = ram_wr_q & rdy;
    assign if_done       = if_done_q;
    assign if_inst       = if_inst_q;
    assign mem_done      = mem_done_q;
    assign mem_rdata     = mem_rdata_q;
    assign if_stall_req  = if_req & ~if_done_q;
    assign mem_stall_req = mem_req & ~mem_done_q;

endmodule
